// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified-memory port arbiter.
package typedefs;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_WAIT = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_LD   = 2'd1,
    OWN_DM   = 2'd2,
    OWN_IF   = 2'd3
  } arb_owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester, read-return and RAM-side signals of the memory port arbiter.
interface mem_port_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              ld_req;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic              ld_gnt;
  logic              ld_rvalid;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;

  logic [DATA_W-1:0] rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  ld_req, ld_we, ld_addr, ld_wdata,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    input  if_req, if_addr,
    input  mem_rdata,
    output ld_gnt, ld_rvalid, dm_gnt, dm_rvalid, if_gnt, if_rvalid,
    output rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output ld_req, ld_we, ld_addr, ld_wdata,
    output dm_req, dm_we, dm_addr, dm_wdata,
    output if_req, if_addr,
    output mem_rdata,
    input  ld_gnt, ld_rvalid, dm_gnt, dm_rvalid, if_gnt, if_rvalid,
    input  rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter_arb_prio_pick.sv
// Combinational winner select: ld > dm > if, with fetch jumping ahead of dm when starved.
module arb_prio_pick
  import typedefs::*;
(
  input  logic       ld_req_i,
  input  logic       dm_req_i,
  input  logic       if_req_i,
  input  logic       starve_i,
  output arb_owner_t winner_o
);

  always_comb begin
    winner_o = OWN_NONE;
    if (ld_req_i) begin
      winner_o = OWN_LD;
    end else if (if_req_i && starve_i) begin
      winner_o = OWN_IF;
    end else if (dm_req_i) begin
      winner_o = OWN_DM;
    end else if (if_req_i) begin
      winner_o = OWN_IF;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM among loader, data path and fetch with a single read in flight;
// writes retire on grant, reads return RD_LAT cycles after grant while new grants are held off.
module mem_port_arbiter
  import typedefs::*;
#(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int STV_W = $clog2(STARVE_MAX + 1);
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(RD_LAT - 1);
  localparam logic [STV_W-1:0] STV_SAT  = STV_W'(STARVE_MAX);

  if (RD_LAT < 1) begin : g_bad_rd_lat
    $error("mem_port_arbiter: RD_LAT must be at least 1");
  end
  if (STARVE_MAX < 1) begin : g_bad_starve_max
    $error("mem_port_arbiter: STARVE_MAX must be at least 1");
  end

  arb_state_t        state_q, state_d;
  arb_owner_t        owner_q, owner_d;
  logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic [STV_W-1:0]  starve_cnt_q, starve_cnt_d;

  arb_owner_t        winner;
  logic              issue;
  logic              deliver;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  arb_prio_pick u_pick (
    .ld_req_i (bus.ld_req),
    .dm_req_i (bus.dm_req),
    .if_req_i (bus.if_req),
    .starve_i (starve_cnt_q == STV_SAT),
    .winner_o (winner)
  );

  always_comb begin
    win_we    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    case (winner)
      OWN_LD: begin
        win_we    = bus.ld_we;
        win_addr  = bus.ld_addr;
        win_wdata = bus.ld_wdata;
      end
      OWN_DM: begin
        win_we    = bus.dm_we;
        win_addr  = bus.dm_addr;
        win_wdata = bus.dm_wdata;
      end
      OWN_IF: begin
        win_addr  = bus.if_addr;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    lat_cnt_d    = lat_cnt_q;
    starve_cnt_d = starve_cnt_q;
    issue        = 1'b0;
    deliver      = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (winner != OWN_NONE) begin
          issue = 1'b1;
          if (!win_we) begin
            owner_d   = winner;
            lat_cnt_d = LAT_INIT;
            state_d   = ARB_WAIT;
          end
        end
        // Count only rounds fetch actually lost to dm; a loader win neither helps nor hurts it.
        if (bus.if_req && (winner == OWN_DM)) begin
          if (starve_cnt_q != STV_SAT) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
          end
        end else if (!bus.if_req || (winner == OWN_IF)) begin
          starve_cnt_d = '0;
        end
      end
      ARB_WAIT: begin
        if (lat_cnt_q == '0) begin
          deliver = 1'b1;
          owner_d = OWN_NONE;
          state_d = ARB_IDLE;
        end else begin
          lat_cnt_d = lat_cnt_q - 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      owner_q      <= OWN_NONE;
      lat_cnt_q    <= '0;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      lat_cnt_q    <= lat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Outputs are forced quiet while reset is held, even though requests may already be up.
  logic grant_ok;
  logic deliver_ok;
  assign grant_ok   = issue && !rst;
  assign deliver_ok = deliver && !rst;

  assign bus.ld_gnt    = grant_ok && (winner == OWN_LD);
  assign bus.dm_gnt    = grant_ok && (winner == OWN_DM);
  assign bus.if_gnt    = grant_ok && (winner == OWN_IF);
  assign bus.mem_en    = grant_ok;
  assign bus.mem_we    = grant_ok && win_we;
  assign bus.mem_addr  = grant_ok ? win_addr : '0;
  assign bus.mem_wdata = grant_ok ? win_wdata : '0;

  assign bus.ld_rvalid = deliver_ok && (owner_q == OWN_LD);
  assign bus.dm_rvalid = deliver_ok && (owner_q == OWN_DM);
  assign bus.if_rvalid = deliver_ok && (owner_q == OWN_IF);
  assign bus.rdata     = deliver_ok ? bus.mem_rdata : '0;
  assign bus.busy      = !rst && (state_q == ARB_WAIT);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (RD_LAT 1 and 3), each with its own RAM model.
module tb_mem_port_arbiter;
  import typedefs::*;

  localparam int SMAX = 4;

  logic clk;
  logic rst;

  logic [1:0]  ld_req, ld_we, dm_req, dm_we, if_req;
  logic [15:0] ld_addr [2];
  logic [15:0] ld_wdata[2];
  logic [15:0] dm_addr [2];
  logic [15:0] dm_wdata[2];
  logic [15:0] if_addr [2];

  logic [1:0]  ld_gnt, dm_gnt, if_gnt, ld_rv, dm_rv, if_rv, t_en, t_we, t_busy;
  logic [15:0] t_addr [2];
  logic [15:0] t_wdata[2];
  logic [15:0] t_rdata[2];

  int checks = 0;
  int errors = 0;

  function automatic logic [15:0] init_val(input int a);
    return 16'(a) ^ 16'hA5C3;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : 3;
    logic [15:0] ram  [0:65535];
    logic [15:0] pipe [0:L-1];

    mem_port_arbiter_if #(.DATA_W(16), .ADDR_W(16)) bus ();

    assign bus.ld_req   = ld_req[g];
    assign bus.ld_we    = ld_we[g];
    assign bus.ld_addr  = ld_addr[g];
    assign bus.ld_wdata = ld_wdata[g];
    assign bus.dm_req   = dm_req[g];
    assign bus.dm_we    = dm_we[g];
    assign bus.dm_addr  = dm_addr[g];
    assign bus.dm_wdata = dm_wdata[g];
    assign bus.if_req   = if_req[g];
    assign bus.if_addr  = if_addr[g];
    assign bus.mem_rdata = pipe[L-1];

    assign ld_gnt[g]  = bus.ld_gnt;
    assign dm_gnt[g]  = bus.dm_gnt;
    assign if_gnt[g]  = bus.if_gnt;
    assign ld_rv[g]   = bus.ld_rvalid;
    assign dm_rv[g]   = bus.dm_rvalid;
    assign if_rv[g]   = bus.if_rvalid;
    assign t_en[g]    = bus.mem_en;
    assign t_we[g]    = bus.mem_we;
    assign t_busy[g]  = bus.busy;
    assign t_addr[g]  = bus.mem_addr;
    assign t_wdata[g] = bus.mem_wdata;
    assign t_rdata[g] = bus.rdata;

    mem_port_arbiter #(
      .DATA_W(16), .ADDR_W(16), .RD_LAT(L), .STARVE_MAX(SMAX)
    ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    initial begin
      for (int i = 0; i < 65536; i++) ram[i] = init_val(i);
    end

    // Synchronous RAM: read data appears L cycles after the sampling edge, junk otherwise.
    always @(posedge clk) begin
      if (bus.mem_en && !bus.mem_we) pipe[0] <= ram[bus.mem_addr];
      else                           pipe[0] <= 16'hDEAD;
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
      if (bus.mem_en && bus.mem_we) ram[bus.mem_addr] = bus.mem_wdata;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  function automatic logic [2:0] gvec(input int d);
    return {ld_gnt[d], dm_gnt[d], if_gnt[d]};
  endfunction

  function automatic logic [2:0] rvec(input int d);
    return {ld_rv[d], dm_rv[d], if_rv[d]};
  endfunction

  task automatic clr_inputs();
    ld_req = '0; ld_we = '0; dm_req = '0; dm_we = '0; if_req = '0;
    for (int d = 0; d < 2; d++) begin
      ld_addr[d] = '0; ld_wdata[d] = '0; dm_addr[d] = '0; dm_wdata[d] = '0; if_addr[d] = '0;
    end
  endtask

  // Transaction-level reference: a read grant at cycle T owns the port until T+L,
  // returning the data memory held at grant time; writes update memory on grant.
  int          m_pend[2], m_done[2], m_own[2], m_starve[2], m_cyc[2];
  logic [15:0] m_rd[2];
  logic [15:0] mm[2][16];

  task automatic model_reset(input int d);
    m_pend[d] = 0; m_done[d] = 0; m_own[d] = 0; m_starve[d] = 0; m_cyc[d] = 0; m_rd[d] = '0;
  endtask

  task automatic model_cycle(input int d);
    int          lat;
    int          w;
    logic [2:0]  eg, ev;
    logic [15:0] erd, ea, ewd;
    logic        ebusy, een, ewe;
    lat = (d == 0) ? 1 : 3;
    eg = '0; ev = '0; erd = '0; ea = '0; ewd = '0; een = 1'b0; ewe = 1'b0;
    ebusy = (m_pend[d] != 0);
    if (m_pend[d] != 0) begin
      if (m_cyc[d] == m_done[d]) begin
        ev = 3'b100 >> (m_own[d] - 1);
        erd = m_rd[d];
        m_pend[d] = 0;
      end
    end else begin
      w = 0;
      if (ld_req[d]) w = 1;
      else if (dm_req[d] && !(if_req[d] && m_starve[d] == SMAX)) w = 2;
      else if (if_req[d]) w = 3;
      if (if_req[d] && w == 2) m_starve[d] = (m_starve[d] < SMAX) ? m_starve[d] + 1 : SMAX;
      else if (!if_req[d] || w == 3) m_starve[d] = 0;
      if (w != 0) begin
        een = 1'b1;
        eg  = 3'b100 >> (w - 1);
        case (w)
          1: begin ewe = ld_we[d]; ea = ld_addr[d]; ewd = ld_wdata[d]; end
          2: begin ewe = dm_we[d]; ea = dm_addr[d]; ewd = dm_wdata[d]; end
          default: begin ewe = 1'b0; ea = if_addr[d]; end
        endcase
        if (ewe) begin
          mm[d][ea[3:0]] = ewd;
        end else begin
          m_pend[d] = 1;
          m_done[d] = m_cyc[d] + lat;
          m_own[d]  = w;
          m_rd[d]   = mm[d][ea[3:0]];
        end
      end
    end
    chk("rnd_gnt", 32'(gvec(d)), 32'(eg));
    chk("rnd_rvalid", 32'(rvec(d)), 32'(ev));
    chk("rnd_busy", 32'(t_busy[d]), 32'(ebusy));
    chk("rnd_mem_en", 32'(t_en[d]), 32'(een));
    if (een) begin
      chk("rnd_mem_we", 32'(t_we[d]), 32'(ewe));
      chk("rnd_mem_addr", 32'(t_addr[d]), 32'(ea));
      if (ewe) chk("rnd_mem_wdata", 32'(t_wdata[d]), 32'(ewd));
    end
    if (ev != 0) chk("rnd_rdata", 32'(t_rdata[d]), 32'(erd));
    m_cyc[d]++;
  endtask

  task automatic drive_rand(input int d, input logic [2:0] g);
    if (g[2]) ld_req[d] = 1'b0;
    if (g[1]) dm_req[d] = 1'b0;
    if (g[0]) if_req[d] = 1'b0;
    if (!ld_req[d] && $urandom_range(0, 99) < 8) begin
      ld_req[d] = 1'b1; ld_we[d] = 1'($urandom_range(0, 1));
      ld_addr[d] = 16'($urandom_range(0, 15)); ld_wdata[d] = 16'($urandom);
    end
    if (!dm_req[d] && $urandom_range(0, 99) < 45) begin
      dm_req[d] = 1'b1; dm_we[d] = 1'($urandom_range(0, 1));
      dm_addr[d] = 16'($urandom_range(0, 15)); dm_wdata[d] = 16'($urandom);
    end
    if (!if_req[d] && $urandom_range(0, 99) < 55) begin
      if_req[d] = 1'b1; if_addr[d] = 16'($urandom_range(0, 15));
    end
  endtask

  typedef struct {
    logic        ld, dm, fi, ld_we, dm_we;
    logic [2:0]  g;
    logic        we;
    logic [15:0] addr;
  } vec_t;

  vec_t        tbl[8];
  logic [2:0]  seq[6];
  logic [2:0]  lastg;
  int          ng;
  logic        clear_next;

  initial begin
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 16'h0000};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b100, 1'b1, 16'h0A00};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b010, 1'b1, 16'h0B00};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 1'b0, 16'h0C00};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'b100, 1'b1, 16'h0A00};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 1'b1, 16'h0B00};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b100, 1'b0, 16'h0A00};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b010, 1'b0, 16'h0B00};

    // Reset held with live requests: everything must stay quiet.
    clr_inputs();
    rst = 1'b1;
    ld_req[0] = 1'b1; ld_we[0] = 1'b1; ld_addr[0] = 16'h1234; ld_wdata[0] = 16'h5678;
    if_req[1] = 1'b1; if_addr[1] = 16'h0009;
    at_neg();
    for (int d = 0; d < 2; d++) begin
      chk("rst_gnt", 32'(gvec(d)), 32'd0);
      chk("rst_rvalid", 32'(rvec(d)), 32'd0);
      chk("rst_mem_en", 32'(t_en[d]), 32'd0);
      chk("rst_mem_we", 32'(t_we[d]), 32'd0);
      chk("rst_busy", 32'(t_busy[d]), 32'd0);
      chk("rst_mem_addr", 32'(t_addr[d]), 32'd0);
      chk("rst_mem_wdata", 32'(t_wdata[d]), 32'd0);
      chk("rst_rdata", 32'(t_rdata[d]), 32'd0);
    end
    chk("rst_starve", 32'(g_dut[0].u_dut.starve_cnt_q), 32'd0);
    tick();
    clr_inputs();
    rst = 1'b0;

    // Priority table on the RD_LAT=1 instance.
    for (int i = 0; i < 8; i++) begin
      ld_req[0] = tbl[i].ld; ld_we[0] = tbl[i].ld_we; ld_addr[0] = 16'h0A00; ld_wdata[0] = 16'h1111;
      dm_req[0] = tbl[i].dm; dm_we[0] = tbl[i].dm_we; dm_addr[0] = 16'h0B00; dm_wdata[0] = 16'h2222;
      if_req[0] = tbl[i].fi; if_addr[0] = 16'h0C00;
      at_neg();
      chk("tbl_gnt", 32'(gvec(0)), 32'(tbl[i].g));
      chk("tbl_mem_en", 32'(t_en[0]), 32'(tbl[i].g != 3'b000));
      chk("tbl_mem_we", 32'(t_we[0]), 32'(tbl[i].we));
      chk("tbl_mem_addr", 32'(t_addr[0]), 32'(tbl[i].addr));
      tick();
      clr_inputs();
      repeat (3) tick();
    end

    // Fetch read of 0x0010, request dropped right after the grant.
    if_req[0] = 1'b1; if_addr[0] = 16'h0010;
    at_neg();
    chk("if_rd_gnt", 32'(gvec(0)), 32'b001);
    chk("if_rd_mem_en", 32'(t_en[0]), 32'd1);
    chk("if_rd_addr", 32'(t_addr[0]), 32'h0010);
    chk("if_rd_busy_T", 32'(t_busy[0]), 32'd0);
    tick();
    if_req[0] = 1'b0;
    at_neg();
    chk("if_rd_rvalid", 32'(rvec(0)), 32'b001);
    chk("if_rd_rdata", 32'(t_rdata[0]), 32'(init_val(16'h0010)));
    chk("if_rd_busy_T1", 32'(t_busy[0]), 32'd1);
    chk("if_rd_no_gnt", 32'(gvec(0)), 32'd0);
    tick();
    at_neg();
    chk("if_rd_busy_T2", 32'(t_busy[0]), 32'd0);
    chk("if_rd_rvalid_T2", 32'(rvec(0)), 32'd0);
    tick();

    // Loader write and dm read of the same word in the same cycle.
    ld_req[0] = 1'b1; ld_we[0] = 1'b1; ld_addr[0] = 16'h0100; ld_wdata[0] = 16'hBEEF;
    dm_req[0] = 1'b1; dm_we[0] = 1'b0; dm_addr[0] = 16'h0100;
    at_neg();
    chk("ldw_gnt", 32'(gvec(0)), 32'b100);
    chk("ldw_mem_we", 32'(t_we[0]), 32'd1);
    chk("ldw_mem_addr", 32'(t_addr[0]), 32'h0100);
    chk("ldw_mem_wdata", 32'(t_wdata[0]), 32'hBEEF);
    tick();
    ld_req[0] = 1'b0; ld_we[0] = 1'b0;
    at_neg();
    chk("dmr_gnt", 32'(gvec(0)), 32'b010);
    chk("dmr_mem_we", 32'(t_we[0]), 32'd0);
    tick();
    dm_req[0] = 1'b0;
    at_neg();
    chk("dmr_rvalid", 32'(rvec(0)), 32'b010);
    chk("dmr_rdata", 32'(t_rdata[0]), 32'hBEEF);
    tick();
    repeat (2) tick();

    // Starvation: dm reads back to back against a waiting fetch.
    for (int i = 0; i < 6; i++) seq[i] = 3'b000;
    dm_req[0] = 1'b1; dm_we[0] = 1'b0; dm_addr[0] = 16'h0200;
    if_req[0] = 1'b1; if_addr[0] = 16'h0300;
    ng = 0;
    clear_next = 1'b0;
    for (int c = 0; c < 40 && ng < 6; c++) begin
      at_neg();
      lastg = gvec(0);
      if (clear_next) begin
        chk("starve_cleared", 32'(g_dut[0].u_dut.starve_cnt_q), 32'd0);
        clear_next = 1'b0;
      end
      if (lastg != 3'b000) begin
        seq[ng] = lastg;
        ng++;
        if (lastg == 3'b001) begin
          chk("starve_sat", 32'(g_dut[0].u_dut.starve_cnt_q), 32'(SMAX));
          clear_next = 1'b1;
        end
      end
      tick();
      if (lastg == 3'b001) if_req[0] = 1'b0;
    end
    dm_req[0] = 1'b0;
    if_req[0] = 1'b0;
    chk("starve_grant_count", 32'(ng), 32'd6);
    for (int i = 0; i < 6; i++)
      chk("starve_seq", 32'(seq[i]), (i == 4) ? 32'b001 : 32'b010);
    repeat (3) tick();

    // Four back-to-back dm writes.
    dm_req[0] = 1'b1; dm_we[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      dm_addr[0] = 16'h0600 + 16'(k); dm_wdata[0] = 16'h7000 + 16'(k);
      at_neg();
      chk("bbw_gnt", 32'(gvec(0)), 32'b010);
      chk("bbw_busy", 32'(t_busy[0]), 32'd0);
      chk("bbw_addr", 32'(t_addr[0]), 32'h0600 + 32'(k));
      tick();
    end
    dm_req[0] = 1'b0; dm_we[0] = 1'b0;
    repeat (2) tick();

    // RD_LAT=3: dm read killed by reset two cycles in, then a fresh fetch.
    dm_req[1] = 1'b1; dm_we[1] = 1'b0; dm_addr[1] = 16'h0400;
    at_neg();
    chk("rw_dm_gnt", 32'(gvec(1)), 32'b010);
    tick();
    dm_req[1] = 1'b0;
    at_neg();
    chk("rw_busy_T1", 32'(t_busy[1]), 32'd1);
    tick();
    rst = 1'b1;
    if_req[1] = 1'b1; if_addr[1] = 16'h0500;
    at_neg();
    chk("rw_rst_gnt", 32'(gvec(1)), 32'd0);
    chk("rw_rst_rvalid", 32'(rvec(1)), 32'd0);
    chk("rw_rst_mem_en", 32'(t_en[1]), 32'd0);
    chk("rw_rst_busy", 32'(t_busy[1]), 32'd0);
    chk("rw_rst_rdata", 32'(t_rdata[1]), 32'd0);
    chk("rw_rst_addr", 32'(t_addr[1]), 32'd0);
    tick();
    at_neg();
    chk("rw_rst_rvalid_T3", 32'(rvec(1)), 32'd0);
    tick();
    rst = 1'b0;
    at_neg();
    chk("rw_if_gnt", 32'(gvec(1)), 32'b001);
    chk("rw_if_addr", 32'(t_addr[1]), 32'h0500);
    chk("rw_no_stale_rvalid", 32'(rvec(1)), 32'd0);
    tick();
    if_req[1] = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      at_neg();
      if (k < 3) begin
        chk("rw_wait_rvalid", 32'(rvec(1)), 32'd0);
        chk("rw_wait_busy", 32'(t_busy[1]), 32'd1);
      end else begin
        chk("rw_if_rvalid", 32'(rvec(1)), 32'b001);
        chk("rw_if_rdata", 32'(t_rdata[1]), 32'(init_val(16'h0500)));
      end
      tick();
    end

    // Randomised traffic against the reference model, one instance at a time.
    for (int d = 0; d < 2; d++) begin
      for (int a = 0; a < 16; a++) mm[d][a] = init_val(a);
    end
    for (int d = 0; d < 2; d++) begin
      clr_inputs();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_reset(d);
      lastg = 3'b000;
      for (int c = 0; c < 1500; c++) begin
        drive_rand(d, lastg);
        at_neg();
        lastg = gvec(d);
        model_cycle(d);
        tick();
      end
      clr_inputs();
      for (int c = 0; c < 5; c++) begin
        at_neg();
        model_cycle(d);
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
